// File: rtl/rf_bist.sv
// Built-in self-test initiator for the 8x16 register file: writes a seed pattern
// and its inverse into every register, reads each back and flags the first mismatch.
module rf_bist #(
    parameter logic [15:0] SEED = 16'hA5C3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] read1data,
    input  logic [15:0] read2data,
    output logic [2:0]  read1regsel,
    output logic [2:0]  read2regsel,
    output logic [2:0]  writeregsel,
    output logic [15:0] writedata,
    output logic        write,
    output logic        busy,
    output logic        done,
    output logic        fail,
    output logic [2:0]  fail_reg
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic        pass_q, pass_d;
    logic        fail_q, fail_d;
    logic [2:0]  fail_reg_q, fail_reg_d;

    logic [2:0]  rd1_sel, rd2_sel;
    logic        miss1, miss2;

    // Pattern for register i in pass p; the index is smeared across the word so
    // every register holds a distinct value within a pass.
    function automatic logic [15:0] exp_val(input logic [2:0] i, input logic p);
        return (p ? ~SEED : SEED) ^ {i, i, i, i, i, 1'b0};
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            fail_reg_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            fail_reg_q <= fail_reg_d;
        end
    end

    assign rd1_sel = {idx_q[1:0], 1'b0};
    assign rd2_sel = {idx_q[1:0], 1'b1};
    assign miss1   = (read1data != exp_val(rd1_sel, pass_q));
    assign miss2   = (read2data != exp_val(rd2_sel, pass_q));

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave it unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        idx_d      = idx_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        fail_reg_d = fail_reg_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = WRITE;
                    idx_d      = '0;
                    pass_d     = 1'b0;
                    fail_d     = 1'b0;
                    fail_reg_d = '0;
                end
            end
            WRITE: begin
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd7) begin
                    state_d = READ;
                    idx_d   = '0;
                end
            end
            READ: begin
                if (miss1 || miss2) begin
                    fail_d = 1'b1;
                    // Only the first failing register is recorded; port 1 wins ties.
                    if (!fail_q) begin
                        fail_reg_d = miss1 ? rd1_sel : rd2_sel;
                    end
                end
                if (idx_q == 3'd3) begin
                    idx_d = '0;
                    if (!pass_q) begin
                        pass_d  = 1'b1;
                        state_d = WRITE;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Port-side outputs depend only on registered state, never on inputs.
    always_comb begin
        read1regsel = '0;
        read2regsel = '0;
        writeregsel = '0;
        writedata   = '0;
        write       = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        unique case (state_q)
            WRITE: begin
                write       = 1'b1;
                writeregsel = idx_q;
                writedata   = exp_val(idx_q, pass_q);
                busy        = 1'b1;
            end
            READ: begin
                read1regsel = rd1_sel;
                read2regsel = rd2_sel;
                busy        = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign fail     = fail_q;
    assign fail_reg = fail_reg_q;

endmodule
